// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one shared main-memory port between an I-cache
// (read-only fill) requester and a D-cache (read/write) requester.
// D wins on contention until it has taken STARVE_LIMIT grants in a row while
// I was waiting; then I is granted once. An IDLE cycle separates grants.
//
// Ports
//   clk, rst           single clock; asynchronous active-low reset
//   i_req/i_addr       I-side request (held until i_done) and fill address
//   i_done             I-side completion pulse (same cycle as mem_done)
//   d_req/d_wr/d_addr/d_wdata  D-side request, direction, address, write data
//   d_done             D-side completion pulse (same cycle as mem_done)
//   rdata              read data, valid only while a done pulse is high
//   mem_req/mem_wr/mem_addr/mem_wdata  shared memory request (level until mem_done)
//   mem_done/mem_rdata memory completion pulse and read data
//   busy               high whenever a grant is outstanding
//   i_grant_cnt/d_grant_cnt  saturating grant counters
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 2   // legal range 1..3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic [15:0] i_grant_cnt,
    output logic [15:0] d_grant_cnt
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned STREAK_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] d_streak;
    logic                grant_i_c;
    logic                grant_d_c;

    // Arbitration decision, only meaningful in IDLE
    always_comb begin
        grant_i_c = 1'b0;
        grant_d_c = 1'b0;
        if (state == IDLE) begin
            if (i_req && d_req) begin
                if (d_streak == STREAK_W'(STARVE_LIMIT)) begin
                    grant_i_c = 1'b1;
                end else begin
                    grant_d_c = 1'b1;
                end
            end else if (i_req) begin
                grant_i_c = 1'b1;
            end else if (d_req) begin
                grant_d_c = 1'b1;
            end
        end
    end

    // State, starvation streak and grant counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            d_streak    <= '0;
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i_c) begin
                        state    <= GNT_I;
                        d_streak <= '0;
                        if (i_grant_cnt != {CNT_W{1'b1}}) begin
                            i_grant_cnt <= i_grant_cnt + CNT_W'(1);
                        end
                    end else if (grant_d_c) begin
                        state <= GNT_D;
                        // Streak only grows while I is actually waiting
                        if (!i_req) begin
                            d_streak <= '0;
                        end else if (d_streak != {STREAK_W{1'b1}}) begin
                            d_streak <= d_streak + STREAK_W'(1);
                        end
                        if (d_grant_cnt != {CNT_W{1'b1}}) begin
                            d_grant_cnt <= d_grant_cnt + CNT_W'(1);
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    // Grant is held until memory completes, even if req drops
                    if (mem_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side mux and completion pulses, all combinational from state
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        rdata     = '0;
        case (state)
            GNT_I: begin
                mem_req  = 1'b1;
                mem_addr = i_addr;
                if (mem_done) begin
                    i_done = 1'b1;
                    rdata  = mem_rdata;
                end
            end
            GNT_D: begin
                mem_req   = 1'b1;
                mem_wr    = d_wr;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                if (mem_done) begin
                    d_done = 1'b1;
                    rdata  = mem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned SL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_done;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_done;
    logic [15:0] rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_done = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        busy;
    logic [15:0] i_grant_cnt;
    logic [15:0] d_grant_cnt;

    mem_arbiter #(.STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
        .rdata(rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .busy(busy), .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who currently owns memory (0 none, 1 I, 2 D),
    // how many D grants in a row I has waited through, and grant totals.
    int m_owner  = 0;
    int m_streak = 0;
    int m_icnt   = 0;
    int m_dcnt   = 0;
    int n_owner, n_streak, n_icnt, n_dcnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner = 0; m_streak = 0; m_icnt = 0; m_dcnt = 0;
        end else begin
            m_owner = n_owner; m_streak = n_streak; m_icnt = n_icnt; m_dcnt = n_dcnt;
        end
    end

    // Every-cycle compare against the model, then model's next step
    always @(negedge clk) begin
        logic        x_req, x_wr, x_idone, x_ddone;
        logic [15:0] x_addr, x_wdata, x_rdata;
        int          who;
        x_req   = (m_owner != 0);
        x_wr    = (m_owner == 2) ? d_wr : 1'b0;
        x_addr  = (m_owner == 1) ? i_addr : (m_owner == 2) ? d_addr : 16'h0;
        x_wdata = (m_owner == 2) ? d_wdata : 16'h0;
        x_idone = (m_owner == 1) && mem_done;
        x_ddone = (m_owner == 2) && mem_done;
        x_rdata = (x_idone || x_ddone) ? mem_rdata : 16'h0;
        chk("mem_req",   16'(mem_req),   16'(x_req));
        chk("mem_wr",    16'(mem_wr),    16'(x_wr));
        chk("mem_addr",  mem_addr,       x_addr);
        chk("mem_wdata", mem_wdata,      x_wdata);
        chk("i_done",    16'(i_done),    16'(x_idone));
        chk("d_done",    16'(d_done),    16'(x_ddone));
        chk("rdata",     rdata,          x_rdata);
        chk("busy",      16'(busy),      16'(x_req));
        chk("i_cnt",     i_grant_cnt,    16'(m_icnt));
        chk("d_cnt",     d_grant_cnt,    16'(m_dcnt));

        n_owner = m_owner; n_streak = m_streak; n_icnt = m_icnt; n_dcnt = m_dcnt;
        if (m_owner != 0) begin
            if (mem_done) n_owner = 0;
        end else begin
            who = 0;
            if (i_req && d_req) who = (m_streak == int'(SL)) ? 1 : 2;
            else if (i_req)     who = 1;
            else if (d_req)     who = 2;
            if (who == 1) begin
                n_owner = 1; n_streak = 0;
                n_icnt = (m_icnt < 65535) ? m_icnt + 1 : 65535;
            end else if (who == 2) begin
                n_owner = 2;
                n_streak = i_req ? ((m_streak < 3) ? m_streak + 1 : 3) : 0;
                n_dcnt = (m_dcnt < 65535) ? m_dcnt + 1 : 65535;
            end
        end
    end

    logic       i_seen = 1'b0;
    logic       d_seen = 1'b0;
    logic [7:0] order [6];
    logic [7:0] want  [6];

    initial begin
        want[0] = "D"; want[1] = "D"; want[2] = "I";
        want[3] = "D"; want[4] = "D"; want[5] = "I";

        #1 rst = 1'b0;
        #11;
        chk("reset_mem_req", 16'(mem_req), 16'h0);
        chk("reset_busy",    16'(busy),    16'h0);
        chk("reset_icnt",    i_grant_cnt,  16'h0);
        @(posedge clk); #1 rst = 1'b1;

        // Single I read, memory answers three cycles after mem_req
        i_req = 1'b1; i_addr = 16'h0040;
        #1 chk("i_lat_before", 16'(mem_req), 16'h0);
        tick();
        chk("i_mem_req", 16'(mem_req), 16'h1);
        chk("i_mem_wr",  16'(mem_wr),  16'h0);
        chk("i_addr",    mem_addr,     16'h0040);
        chk("i_cnt1",    i_grant_cnt,  16'h0001);
        tick(); tick(); tick();
        mem_done = 1'b1; mem_rdata = 16'hBEEF;
        #1 chk("i_done_pulse", 16'(i_done), 16'h1);
        chk("i_rdata", rdata, 16'hBEEF);
        tick();
        mem_done = 1'b0; i_req = 1'b0;
        #1 chk("i_done_after", 16'(i_done), 16'h0);
        chk("i_idle_busy", 16'(busy), 16'h0);

        // D write
        tick();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h1000; d_wdata = 16'h1234;
        tick();
        chk("d_mem_wr",    16'(mem_wr), 16'h1);
        chk("d_mem_addr",  mem_addr,    16'h1000);
        chk("d_mem_wdata", mem_wdata,   16'h1234);
        tick();
        mem_done = 1'b1; mem_rdata = 16'h0;
        #1 chk("d_done_pulse", 16'(d_done), 16'h1);
        chk("d_no_idone", 16'(i_done), 16'h0);
        tick();
        mem_done = 1'b0; d_req = 1'b0; d_wr = 1'b0;

        // Starvation: both held high, D D I D D I
        tick();
        i_req = 1'b1; i_addr = 16'h0100; d_req = 1'b1; d_addr = 16'h0200;
        for (int g = 0; g < 6; g++) begin
            tick();
            mem_done = 1'b1; mem_rdata = 16'(g);
            #1 order[g] = i_done ? "I" : (d_done ? "D" : "-");
            tick();
            mem_done = 1'b0;
        end
        i_req = 1'b0; d_req = 1'b0;
        for (int g = 0; g < 6; g++) chk($sformatf("order%0d", g), 16'(order[g]), 16'(want[g]));

        // Reset during GNT_D before mem_done
        tick();
        d_req = 1'b1; d_addr = 16'h2222;
        tick(); tick();
        #2 rst = 1'b0;
        #1 chk("rst_mem_req", 16'(mem_req), 16'h0);
        chk("rst_busy",   16'(busy),   16'h0);
        chk("rst_d_done", 16'(d_done), 16'h0);
        chk("rst_icnt",   i_grant_cnt, 16'h0);
        chk("rst_dcnt",   d_grant_cnt, 16'h0);
        d_req = 1'b0;
        tick(); tick();
        rst = 1'b1;

        // d_req dropped one cycle into GNT_D
        tick();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h3000; d_wdata = 16'h5555;
        tick();
        tick();
        d_req = 1'b0;
        tick();
        chk("drop_hold_req", 16'(mem_req), 16'h1);
        mem_done = 1'b1; mem_rdata = 16'h0A0A;
        #1 chk("drop_d_done", 16'(d_done), 16'h1);
        tick();
        mem_done = 1'b0; d_wr = 1'b0;
        #1 chk("drop_d_done_once", 16'(d_done), 16'h0);
        chk("drop_idle", 16'(mem_req), 16'h0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (mem_done) mem_done = 1'b0;
            else if ($urandom_range(3) == 0) begin
                mem_done = 1'b1; mem_rdata = 16'($urandom);
            end
            if (i_req && i_seen) begin
                if ($urandom_range(1) == 0) i_req = 1'b0;
            end else if (!i_req && $urandom_range(2) == 0) begin
                i_req = 1'b1; i_addr = 16'($urandom);
            end
            if (d_req && d_seen) begin
                if ($urandom_range(1) == 0) d_req = 1'b0;
            end else if (!d_req && $urandom_range(2) == 0) begin
                d_req = 1'b1; d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
            #3;
            i_seen = i_done; d_seen = d_done;
            @(posedge clk); #1;
        end
        i_req = 1'b0; d_req = 1'b0; mem_done = 1'b0;

        // Counter saturation: 65535 I grants, then one more
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        i_req = 1'b1; i_addr = 16'h0004; mem_done = 1'b1;
        for (int g = 0; g < 65534; g++) begin
            tick(); tick();
        end
        chk("sat_fffe", i_grant_cnt, 16'hFFFE);
        tick(); tick();
        chk("sat_ffff", i_grant_cnt, 16'hFFFF);
        tick();
        chk("sat_hold_req", 16'(mem_req), 16'h1);
        chk("sat_hold", i_grant_cnt, 16'hFFFF);
        tick();
        i_req = 1'b0; mem_done = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter STARVE_LIMIT, default 2, maximum consecutive D-side grants while I-side is pending (range 1..3).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port i_req  input  1  I-cache miss request; held high until i_done.
REQ-005 SHALL provide port i_addr  input  16  I-cache fill address; stable while i_req is high.
REQ-006 SHALL provide port i_done  output  1  one-cycle pulse: I transaction complete.
REQ-007 SHALL provide port d_req  input  1  D-cache miss/writeback request; held high until d_done.
REQ-008 SHALL provide port d_wr  input  1  D-side request is a write; stable while d_req is high.
REQ-009 SHALL provide port d_addr  input  16  D-side address; stable while d_req is high.
REQ-010 SHALL provide port d_wdata  input  16  D-side write data; stable while d_req is high.
REQ-011 SHALL provide port d_done  output  1  one-cycle pulse: D transaction complete.
REQ-012 SHALL provide port rdata  output  16  read data; valid only in the cycle i_done or d_done is high.
REQ-013 SHALL provide port mem_req  output  1  request to shared main memory; level, held until mem_done.
REQ-014 SHALL provide port mem_wr  output  1  memory write enable; I-side is always read.
REQ-015 SHALL provide port mem_addr  output  16  memory address.
REQ-016 SHALL provide port mem_wdata  output  16  memory write data.
REQ-017 SHALL provide port mem_done  input  1  one-cycle pulse from memory: access complete.
REQ-018 SHALL provide port mem_rdata  input  16  memory read data; valid with mem_done.
REQ-019 SHALL provide port busy  output  1  high whenever state is not IDLE.
REQ-020 SHALL provide ports i_grant_cnt and d_grant_cnt  output  16 each  number of grants issued, saturating at 0xFFFF.

Function
REQ-021 SHALL implement FSM states IDLE, GNT_I, GNT_D.
REQ-022 SHALL in IDLE sample i_req and d_req each cycle; with only one high, enter that side's grant state on the next edge.
REQ-023 SHALL on simultaneous requests grant D, unless d_streak == STARVE_LIMIT, in which case grant I.
REQ-024 SHALL hold 2-bit d_streak: increment (saturating) on each D grant taken while i_req is high; clear on each I grant; clear on a D grant taken while i_req is low.
REQ-025 SHALL in GNT_x drive mem_req=1 and mux mem_addr/mem_wr/mem_wdata combinationally from side x (mem_wr=0, mem_wdata=0 for I).
REQ-026 SHALL drive mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0 in IDLE.
REQ-027 SHALL in GNT_x, when mem_done=1, pulse x_done combinationally in that same cycle with rdata=mem_rdata, then return to IDLE on the next edge.
REQ-028 SHALL drive rdata=0 whenever neither done is asserted.
REQ-029 SHALL impose one IDLE cycle between transactions: minimum request-to-mem_req latency 1 cycle; back-to-back grants 1 cycle apart.
REQ-030 SHALL, if a requester drops req while granted, still hold the grant until mem_done and still pulse x_done.
REQ-031 SHALL ignore mem_done while in IDLE.
REQ-032 SHALL increment the matching grant counter on the IDLE->GNT_x transition edge.
REQ-033 SHALL never assert i_done and d_done in the same cycle.

Reset
REQ-034 SHALL on rst low immediately force state IDLE, d_streak=0, both counters 0, and all outputs 0, including mid-transaction; an aborted transaction produces no done pulse.
REQ-035 SHALL start arbitration on the first rising edge after rst returns high.

Verification
REQ-036 SHALL test a single I read: i_req=1, i_addr=0x0040, mem_done 3 cycles after mem_req with mem_rdata=0xBEEF -> mem_req one cycle after i_req, mem_wr=0, i_done pulse with rdata=0xBEEF, i_grant_cnt=1.
REQ-037 SHALL test a D write: d_req=1, d_wr=1, d_addr=0x1000, d_wdata=0x1234 -> mem_wr=1, mem_addr=0x1000, mem_wdata=0x1234, d_done pulse coincident with mem_done.
REQ-038 SHALL test starvation with STARVE_LIMIT=2 and i_req, d_req both held high -> grant order D, D, I, D, D, I.
REQ-039 SHALL test rst asserted low during GNT_D before mem_done -> mem_req=0 and busy=0 immediately, no d_done pulse, counters=0.
REQ-040 SHALL test d_req dropped one cycle into GNT_D -> mem_req held until mem_done, and d_done pulses once.
REQ-041 SHALL test i_grant_cnt preloaded to 0xFFFF via 65535 grants, then one more I grant -> count remains 0xFFFF.
